i2s_adc_serializer: RTL
=======================

# i2s_adc_serializer

Serializes stereo 16-bit PCM samples onto the codec ADC data line (AUD_ADCDAT) in the same I2S framing the audio path deserializes: MSB first, left channel while LRCK is high, data stable on BCLK falling edges. It is the transmit end of the ADC link, used as a codec stand-in for loopback self-test and FX verification. It sits in the CLOCK_50 domain, buffers samples in a small FIFO behind a valid/ready port, and tracks the externally generated BCLK/LRCK through synchronizers.

## Interface
- WIDTH, 16, sample width per channel
- DEPTH, 4, FIFO depth in stereo pairs (power of 2, ≥2)
- SYNC_STAGES, 2, synchronizer flops on AUD_BCLK / AUD_LRCK
- CLOCK_50  in  1  system clock
- RST  in  1  reset; synchronous, active-high
- enable  in  1  start/stop serialization
- s_valid  in  1  sample pair offered
- s_ready  out  1  FIFO can accept (= not full)
- s_left  in  WIDTH  left sample
- s_right  in  WIDTH  right sample
- AUD_BCLK  in  1  bit clock (async, from audio clock generator)
- AUD_LRCK  in  1  LR clock (async; 1 = left)
- AUD_ADCDAT  out  1  serial data to the ADC receiver
- level  out  $clog2(DEPTH)+1  FIFO occupancy
- underrun  out  1  one-cycle pulse: frame started with FIFO empty
- underrun_sticky  out  1  set by underrun, cleared by RST or enable rising

## Operation
- Sync: BCLK/LRCK pass SYNC_STAGES flops plus one history flop; bclk_rise, lrck_rise, lrck_fall are single-cycle strobes.
- FIFO: push when s_valid && s_ready; s_ready = !(level == DEPTH) from registered level; push accepted while full is impossible. Push and pop same cycle: level unchanged. Pop only at lrck_rise in active states.
- States: IDLE, WAIT_FRAME, SHIFT_L, SHIFT_R.
- IDLE: AUD_ADCDAT = 0; FIFO still accepts pushes. enable=1 -> WAIT_FRAME.
- WAIT_FRAME: wait for lrck_rise (never start mid-frame). enable=0 -> IDLE.
- On lrck_rise (from WAIT_FRAME or SHIFT_R): if FIFO non-empty pop into hold {L,R}; else hold = 0, pulse underrun. Load shift reg with L, bit_cnt = 0, drive MSB immediately -> SHIFT_L.
- SHIFT_L/SHIFT_R: each bclk_rise shifts left one, bit_cnt++ saturating at WIDTH; after WIDTH rises data is 0 padding until next LRCK edge.
- On lrck_fall in SHIFT_L: load R from hold -> SHIFT_R. lrck_fall in other states ignored.
- On lrck_rise in SHIFT_R: if enable=0 -> IDLE, drive 0, no pop; else reload as above. enable drop mid-frame completes the current frame.
- LRCK edge and bclk_rise same cycle: LRCK load wins, no shift.
- lrck_rise seen in SHIFT_L (missed fall): treat as new frame (pop/reload), no error.
- Reset mid-frame: everything returns to reset values next cycle; FIFO contents discarded.
- Reset values: AUD_ADCDAT 0, level 0, underrun 0, underrun_sticky 0, state IDLE; s_ready 1 after reset.

## Timing
- Strobe latency: SYNC_STAGES+1 CLOCK_50 cycles after pin edge; AUD_ADCDAT registered, changes 1 cycle after strobe (4 cycles, 80 ns, at defaults).
- Requirement: BCLK high and low phases each ≥ SYNC_STAGES+3 CLOCK_50 cycles so data settles before the receiver's falling-edge sample.
- MSB valid SYNC_STAGES+2 cycles after LRCK edge, before the first BCLK falling edge of the half-frame.
- Pop to MSB on pin: same cycle as L load (1 cycle after lrck_rise strobe).
- s_ready reflects a pop the cycle after it occurs.

## Test plan
- Reset, enable=1, push {L=16'hA5C3, R=16'h0F0F}, run BCLK=1.536 MHz/LRCK=48 kHz -> a falling-edge-sampling receiver model captures L=A5C3, R=0F0F; bits after 16th are 0.
- enable with FIFO empty -> underrun pulses once per frame, sticky=1, received samples 0000/0000; push later -> next frame carries data, sticky stays set until enable re-rise.
- Push 5 pairs with no LRCK -> s_ready drops after 4th, level=4, 5th held; after one lrck_rise level=3, 5th accepted next cycle.
- Assert enable mid-left-half -> AUD_ADCDAT stays 0 until next LRCK rise; first captured frame is first pushed pair.
- Deassert enable during SHIFT_L -> right channel still sent, IDLE at next LRCK rise, level unchanged afterwards.
- Assert RST during bit 7 of left -> next cycle AUD_ADCDAT=0, level=0, s_ready=1; re-enable restarts cleanly at next frame.

Source files
------------

// File: rtl/i2s_adc_serializer.sv
// rtl/i2s_adc_serializer.sv - I2S ADC-line serializer: sample-pair FIFO, BCLK/LRCK synchronizers, MSB-first shifter
module i2s_adc_serializer #(
  parameter int WIDTH       = 16,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   CLOCK_50,
  input  logic                   RST,
  input  logic                   enable,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [WIDTH-1:0]       s_left,
  input  logic [WIDTH-1:0]       s_right,
  input  logic                   AUD_BCLK,
  input  logic                   AUD_LRCK,
  output logic                   AUD_ADCDAT,
  output logic [$clog2(DEPTH):0] level,
  output logic                   underrun,
  output logic                   underrun_sticky
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, WAIT_FRAME, SHIFT_L, SHIFT_R} state_t;

  logic [SYNC_STAGES-1:0] bclk_sync_q, bclk_sync_d, lrck_sync_q, lrck_sync_d;
  logic                   bclk_hist_q, bclk_hist_d, lrck_hist_q, lrck_hist_d;
  logic                   bclk_rise_q, bclk_rise_d;
  logic                   lrck_rise_q, lrck_rise_d, lrck_fall_q, lrck_fall_d;
  logic [2*WIDTH-1:0]     mem_q [DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]          level_q, level_d;
  state_t                 state_q, state_d;
  logic [2*WIDTH-1:0]     hold_q, hold_d;
  logic [WIDTH-1:0]       shift_q, shift_d;
  logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
  logic                   dat_q, dat_d;
  logic                   underrun_q, underrun_d;
  logic                   sticky_q, sticky_d;
  logic                   enable_q, enable_d;
  logic                   push, pop, load_l;

  assign s_ready         = (level_q != LW'(DEPTH));
  assign push            = s_valid && s_ready;
  assign level           = level_q;
  assign AUD_ADCDAT      = dat_q;
  assign underrun        = underrun_q;
  assign underrun_sticky = sticky_q;

  always_comb begin
    bclk_sync_d = (bclk_sync_q << 1) | SYNC_STAGES'(AUD_BCLK);
    lrck_sync_d = (lrck_sync_q << 1) | SYNC_STAGES'(AUD_LRCK);
    bclk_hist_d = bclk_sync_q[SYNC_STAGES-1];
    lrck_hist_d = lrck_sync_q[SYNC_STAGES-1];
    bclk_rise_d = bclk_sync_q[SYNC_STAGES-1] & ~bclk_hist_q;
    lrck_rise_d = lrck_sync_q[SYNC_STAGES-1] & ~lrck_hist_q;
    lrck_fall_d = ~lrck_sync_q[SYNC_STAGES-1] & lrck_hist_q;
  end

  // Synchronizers stay unreset so a reset while LRCK is high cannot fake an LRCK edge.
  always_ff @(posedge CLOCK_50) begin
    bclk_sync_q <= bclk_sync_d;
    lrck_sync_q <= lrck_sync_d;
    bclk_hist_q <= bclk_hist_d;
    lrck_hist_q <= lrck_hist_d;
    if (push) mem_q[wr_ptr_q] <= {s_left, s_right};
  end

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    dat_d      = dat_q;
    underrun_d = 1'b0;
    pop        = 1'b0;
    load_l     = 1'b0;
    case (state_q)
      IDLE: begin
        dat_d = 1'b0;
        if (enable) state_d = WAIT_FRAME;
      end
      WAIT_FRAME: begin
        dat_d = 1'b0;
        if (!enable) state_d = IDLE;
        else if (lrck_rise_q) load_l = 1'b1;
      end
      SHIFT_L, SHIFT_R: begin
        if (lrck_rise_q) begin
          if (state_q == SHIFT_R && !enable) begin
            state_d = IDLE;
            dat_d   = 1'b0;
          end else begin
            load_l = 1'b1;
          end
        end else if (lrck_fall_q && state_q == SHIFT_L) begin
          shift_d   = hold_q[WIDTH-1:0];
          bit_cnt_d = '0;
          dat_d     = hold_q[WIDTH-1];
          state_d   = SHIFT_R;
        end else if (bclk_rise_q) begin
          shift_d = {shift_q[WIDTH-2:0], 1'b0};
          dat_d   = (bit_cnt_q < CW'(WIDTH - 1)) ? shift_q[WIDTH-2] : 1'b0;
          if (bit_cnt_q != CW'(WIDTH)) bit_cnt_d = bit_cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (load_l) begin
      if (level_q != '0) begin
        pop    = 1'b1;
        hold_d = mem_q[rd_ptr_q];
      end else begin
        hold_d     = '0;
        underrun_d = 1'b1;
      end
      shift_d   = hold_d[2*WIDTH-1:WIDTH];
      bit_cnt_d = '0;
      dat_d     = hold_d[2*WIDTH-1];
      state_d   = SHIFT_L;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    enable_d = enable;
    if (underrun_d) sticky_d = 1'b1;
    else if (enable && !enable_q) sticky_d = 1'b0;
    else sticky_d = sticky_q;
  end

  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      bclk_rise_q <= 1'b0;
      lrck_rise_q <= 1'b0;
      lrck_fall_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      state_q     <= IDLE;
      hold_q      <= '0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      dat_q       <= 1'b0;
      underrun_q  <= 1'b0;
      sticky_q    <= 1'b0;
      enable_q    <= 1'b0;
    end else begin
      bclk_rise_q <= bclk_rise_d;
      lrck_rise_q <= lrck_rise_d;
      lrck_fall_q <= lrck_fall_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      state_q     <= state_d;
      hold_q      <= hold_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      dat_q       <= dat_d;
      underrun_q  <= underrun_d;
      sticky_q    <= sticky_d;
      enable_q    <= enable_d;
    end
  end
endmodule
